alu_mem_stage: RTL and testbench
================================

// Module: alu_mem_stage
// PURPOSE
//  Execute + memory stage of the single-cycle RV32 core: decodes ALU control from
//  alu_op/funct3/funct7, computes a 32-bit ALU result and zero flag, and performs a
//  word-addressed data-memory access at that address. A writeback mux picks ALU or
//  memory data. Sits between the register file/extend unit and register writeback.
// PARAMETERS
//  DEPTH  64  data memory size in 32-bit words (power of two)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high reset
//  alu_op       in   2   from main decoder: 00 add, 01 sub, 10 funct-decoded, 11 reserved
//  funct3       in   3   instr[14:12]
//  funct7       in   7   instr[31:25]
//  op5          in   1   instr[5] (1 = R-type, 0 = I-type)
//  src_a        in   32  ALU operand A (rs1 data)
//  src_b        in   32  ALU operand B (rs2 data or immediate, already muxed)
//  mem_write    in   1   data-memory write enable
//  write_data   in   32  store data (rs2 data)
//  result_src   in   1   0 = ALU result, 1 = memory read data
//  alu_control  out  3   decoded ALU operation
//  alu_result   out  32  ALU result; also the memory byte address
//  zero         out  1   1 when alu_result == 0
//  read_data    out  32  memory word at alu_result
//  result       out  32  writeback value
// BEHAVIOUR
//  - One clock, clk; reset synchronous active-high. Only state is the memory array.
//  - Decoder (combinational): alu_op 00->000; 01->001; 11->000.
//    alu_op 10 by funct3: 000 -> 001 if {op5,funct7[5]}==11 else 000; 001->110 (sll);
//    010->101 (slt); 100->100 (xor); 101->111 (srl); 110->011 (or); 111->010 (and);
//    011 -> 000.
//  - ALU (combinational): 000 a+b, 001 a-b (mod 2^32, no carry/overflow out);
//    010 a&b; 011 a|b; 100 a^b; 101 slt signed -> {31'b0, $signed(a)<$signed(b)};
//    110 a<<b[4:0]; 111 a>>b[4:0] logical. zero = (alu_result==32'd0).
//  - Memory: word index = alu_result[log2(DEPTH)+1:2]; upper bits ignored (wraps);
//    alu_result[1:0] ignored (no misaligned trap). Read is combinational/asynchronous.
//  - Write: on rising clk when mem_write=1 and reset=0, mem[index] <= write_data;
//    read_data shows new value after the edge. Same-cycle read sees old value.
//  - Reset: on rising clk with reset=1 all DEPTH words cleared to 0; reset beats a
//    simultaneous mem_write. Combinational outputs have no reset value; after the
//    reset edge read_data = 0 for every address.
//  - result = result_src ? read_data : alu_result (combinational).
// TESTING
//  1 alu_op=10,f3=000,op5=1,f7=0100000,a=7,b=7 -> alu_control=001, alu_result=0, zero=1
//  2 alu_op=10,f3=000,op5=0,f7=0100000,a=5,b=3 -> alu_control=000 (addi), alu_result=8
//  3 slt a=32'hFFFFFFFF,b=1 -> 1; and a=F0F0F0F0,b=FF00FF00 -> F000F000; sll a=1,b=35 -> 8
//  4 sw: a=0,b=8,mem_write=1,write_data=DEADBEEF, clk edge; then lw result_src=1 -> result=DEADBEEF
//  5 address wrap: write 12345678 at byte addr 4*DEPTH+8, read at addr 8 -> 12345678
//  6 reset=1 with mem_write=1 at addr 8, one edge -> read_data at addr 8 (and all) = 0

Source files
------------

// File: rtl/alu_mem_if.sv
// -----------------------------------------------------------------------------
// alu_mem_if
//   Bundles the datapath signals between the decode/register-read side of the
//   RV32 core and the execute + memory stage.
//
//   master : the upstream side that drives ALU controls, operands and
//            memory controls, and receives the stage results.
//   slave  : the execute + memory stage itself.
//
//   Signals
//     alu_op      [1:0]   main-decoder ALU class (00 add, 01 sub, 10 funct, 11 rsvd)
//     funct3      [2:0]   instr[14:12]
//     funct7      [6:0]   instr[31:25]
//     op5                 instr[5] (1 = R-type, 0 = I-type)
//     src_a       [31:0]  ALU operand A
//     src_b       [31:0]  ALU operand B
//     mem_write           data-memory write enable
//     write_data  [31:0]  store data
//     result_src          writeback select (0 = ALU, 1 = memory)
//     alu_control [2:0]   decoded ALU operation
//     alu_result  [31:0]  ALU result / memory byte address
//     zero                alu_result == 0
//     read_data   [31:0]  memory word at alu_result
//     result      [31:0]  writeback value
// -----------------------------------------------------------------------------
interface alu_mem_if;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        op5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mem_write;
    logic [31:0] write_data;
    logic        result_src;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;
    logic [31:0] result;

    modport master (
        output alu_op, funct3, funct7, op5, src_a, src_b,
               mem_write, write_data, result_src,
        input  alu_control, alu_result, zero, read_data, result
    );

    modport slave (
        input  alu_op, funct3, funct7, op5, src_a, src_b,
               mem_write, write_data, result_src,
        output alu_control, alu_result, zero, read_data, result
    );
endinterface

// File: rtl/alu_mem_stage.sv
// -----------------------------------------------------------------------------
// alu_mem_stage
//   Execute + memory stage of the single-cycle RV32 core. Decodes the ALU
//   operation from alu_op/funct3/funct7/op5, computes the 32-bit result and
//   zero flag, accesses a word-addressed data memory at that address, and
//   selects the writeback value.
//
//   Parameters
//     DEPTH   data memory size in 32-bit words (power of two)
//
//   Ports
//     clk     rising-edge clock
//     reset   synchronous, active-high; clears every memory word
//     bus     alu_mem_if.slave carrying all datapath inputs and outputs
//
//   The memory array is the only state. Reads are asynchronous; a write is
//   visible on read_data after the clock edge that performs it.
// -----------------------------------------------------------------------------
module alu_mem_stage #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    alu_mem_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    alu_ctrl_e   alu_ctrl;
    logic [31:0] alu_res;
    logic [AW-1:0] word_idx;
    logic [31:0] mem [DEPTH];

    // ---------------------------------------------------------------- decoder
    always_comb begin
        // NOTE: assign a default before the case so every path drives
        // alu_ctrl; a missing branch would otherwise infer a latch.
        alu_ctrl = ALU_ADD;
        unique case (bus.alu_op)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            2'b10: begin
                unique case (bus.funct3)
                    // sub only for R-type with funct7[5]; addi never subtracts
                    3'b000:  alu_ctrl = ({bus.op5, bus.funct7[5]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_ADD;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;   // reserved encoding
        endcase
    end

    // -------------------------------------------------------------------- ALU
    always_comb begin
        alu_res = '0;
        unique case (alu_ctrl)
            ALU_ADD: alu_res = bus.src_a + bus.src_b;
            ALU_SUB: alu_res = bus.src_a - bus.src_b;
            ALU_AND: alu_res = bus.src_a & bus.src_b;
            ALU_OR:  alu_res = bus.src_a | bus.src_b;
            ALU_XOR: alu_res = bus.src_a ^ bus.src_b;
            ALU_SLT: alu_res = {31'b0, $signed(bus.src_a) < $signed(bus.src_b)};
            ALU_SLL: alu_res = bus.src_a << bus.src_b[4:0];
            ALU_SRL: alu_res = bus.src_a >> bus.src_b[4:0];
            default: alu_res = '0;
        endcase
    end

    // ----------------------------------------------------------- data memory
    // Byte address -> word index; high bits wrap, low two bits are ignored.
    assign word_idx = alu_res[AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: clearing every word makes this array flops rather than a
            // RAM macro; the stage contract requires all-zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.mem_write) begin
            // NOTE: non-blocking so same-cycle reads see the pre-edge value.
            mem[word_idx] <= bus.write_data;
        end
    end

    // Bits that intentionally do not affect the design.
    logic unused_bits;
    assign unused_bits = ^{alu_res[31:AW+2], alu_res[1:0],
                           bus.funct7[6], bus.funct7[4:0]};

    // ---------------------------------------------------------------- outputs
    assign bus.alu_control = alu_ctrl;
    assign bus.alu_result  = alu_res;
    assign bus.zero        = (alu_res == 32'd0);
    assign bus.read_data   = mem[word_idx];
    assign bus.result      = bus.result_src ? bus.read_data : alu_res;

endmodule

// File: tb/tb_alu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_mem_stage
//   Directed-vector bench for alu_mem_stage (DEPTH = 64). Inputs change 1 ns
//   after a rising edge; outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_alu_mem_stage;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_mem_if bus ();

    alu_mem_stage #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive the ALU-side inputs and let the combinational path settle.
    task automatic set_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic o5, input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.op5    = o5;
        bus.src_a  = a;
        bus.src_b  = b;
        #1;
    endtask

    // Plain address computation via add (alu_op 00).
    task automatic set_addr(input logic [31:0] a, input logic [31:0] b);
        set_alu(2'b00, 3'b000, 7'b0, 1'b0, a, b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.mem_write  = 1'b0;
        bus.write_data = '0;
        bus.result_src = 1'b0;
        set_addr(32'd0, 32'd0);

        // ------------------------------------------------ reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_addr(32'd0, 32'd0);    check("rst_rd_0",   bus.read_data, 32'h0);
        set_addr(32'd8, 32'd0);    check("rst_rd_8",   bus.read_data, 32'h0);
        set_addr(32'd252, 32'd0);  check("rst_rd_252", bus.read_data, 32'h0);

        // ------------------------------------------------ ALU / decoder
        set_alu(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd7, 32'd7);
        check("sub_ctrl", {29'b0, bus.alu_control}, 32'd1);
        check("sub_res",  bus.alu_result, 32'd0);
        check("sub_zero", {31'b0, bus.zero}, 32'd1);

        set_alu(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd5, 32'd3);
        check("addi_ctrl", {29'b0, bus.alu_control}, 32'd0);
        check("addi_res",  bus.alu_result, 32'd8);
        check("addi_zero", {31'b0, bus.zero}, 32'd0);

        set_alu(2'b10, 3'b010, 7'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        check("slt_ctrl", {29'b0, bus.alu_control}, 32'd5);
        check("slt_res",  bus.alu_result, 32'd1);

        set_alu(2'b10, 3'b010, 7'b0, 1'b1, 32'd1, 32'hFFFF_FFFF);
        check("slt_res_neg", bus.alu_result, 32'd0);

        set_alu(2'b10, 3'b111, 7'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_ctrl", {29'b0, bus.alu_control}, 32'd2);
        check("and_res",  bus.alu_result, 32'hF000_F000);

        set_alu(2'b10, 3'b001, 7'b0, 1'b1, 32'd1, 32'd35);
        check("sll_ctrl", {29'b0, bus.alu_control}, 32'd6);
        check("sll_res",  bus.alu_result, 32'd8);

        set_alu(2'b10, 3'b101, 7'b0, 1'b1, 32'h8000_0000, 32'd4);
        check("srl_ctrl", {29'b0, bus.alu_control}, 32'd7);
        check("srl_res",  bus.alu_result, 32'h0800_0000);

        set_alu(2'b10, 3'b110, 7'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F);
        check("or_ctrl", {29'b0, bus.alu_control}, 32'd3);
        check("or_res",  bus.alu_result, 32'h0000_00FF);

        set_alu(2'b10, 3'b100, 7'b0, 1'b1, 32'hAAAA_5555, 32'hFFFF_0000);
        check("xor_ctrl", {29'b0, bus.alu_control}, 32'd4);
        check("xor_res",  bus.alu_result, 32'h5555_5555);

        set_alu(2'b01, 3'b111, 7'b0, 1'b1, 32'd3, 32'd5);
        check("op01_ctrl", {29'b0, bus.alu_control}, 32'd1);
        check("op01_res",  bus.alu_result, 32'hFFFF_FFFE);

        set_alu(2'b11, 3'b111, 7'b0100000, 1'b1, 32'd3, 32'd5);
        check("op11_ctrl", {29'b0, bus.alu_control}, 32'd0);
        check("op11_res",  bus.alu_result, 32'd8);

        set_alu(2'b10, 3'b011, 7'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        check("f3_011_ctrl", {29'b0, bus.alu_control}, 32'd0);
        check("f3_011_res",  bus.alu_result, 32'd0);
        check("f3_011_zero", {31'b0, bus.zero}, 32'd1);

        // ------------------------------------------------ store / load
        set_addr(32'd0, 32'd8);
        bus.mem_write  = 1'b1;
        bus.write_data = 32'hDEAD_BEEF;
        #1;
        check("sw_old_val", bus.read_data, 32'h0);
        tick();
        bus.mem_write  = 1'b0;
        bus.result_src = 1'b1;
        #1;
        check("lw_rd",     bus.read_data, 32'hDEAD_BEEF);
        check("lw_result", bus.result,    32'hDEAD_BEEF);
        bus.result_src = 1'b0;
        #1;
        check("alu_result_sel", bus.result, 32'd8);
        set_addr(32'd0, 32'd10);
        check("misalign_rd", bus.read_data, 32'hDEAD_BEEF);
        set_addr(32'd0, 32'd12);
        check("neighbour_rd", bus.read_data, 32'h0);

        // ------------------------------------------------ address wrap
        set_addr(32'd256, 32'd8);   // byte 4*DEPTH + 8
        bus.mem_write  = 1'b1;
        bus.write_data = 32'h1234_5678;
        tick();
        bus.mem_write = 1'b0;
        set_addr(32'd0, 32'd8);
        bus.result_src = 1'b1;
        #1;
        check("wrap_rd",     bus.read_data, 32'h1234_5678);
        check("wrap_result", bus.result,    32'h1234_5678);
        bus.result_src = 1'b0;

        // second word, to confirm reset clears more than the target address
        set_addr(32'd0, 32'd252);
        bus.mem_write  = 1'b1;
        bus.write_data = 32'hCAFE_F00D;
        tick();
        bus.mem_write = 1'b0;
        #1;
        check("top_word_rd", bus.read_data, 32'hCAFE_F00D);

        // ------------------------------------------------ reset beats write
        set_addr(32'd0, 32'd8);
        reset          = 1'b1;
        bus.mem_write  = 1'b1;
        bus.write_data = 32'hFFFF_FFFF;
        tick();
        reset         = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        check("rst_wr_rd_8",   bus.read_data, 32'h0);
        set_addr(32'd0, 32'd252);
        check("rst_wr_rd_252", bus.read_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
